para_rr_mux: RTL
================

PARA_RR_MUX -- requirements
Module: para_rr_mux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each channel data word.
REQ-002 SHALL have parameter NUM_INPUTS, default 4, number of input channels; legal range 2..16.
REQ-003 SHALL have localparam SEL_WIDTH = clog2(NUM_INPUTS), minimum 1.
REQ-004 clk  input  1  the only clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 in_data  input  NUM_INPUTS*DATA_WIDTH  flattened channel data; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 in_valid  input  NUM_INPUTS  per-channel request, bit i = channel i.
REQ-008 in_ready  output  NUM_INPUTS  per-channel accept, bit i = channel i.
REQ-009 out_data  output  DATA_WIDTH  registered selected word.
REQ-010 out_sel  output  SEL_WIDTH  registered index of channel that supplied out_data.
REQ-011 out_valid  output  1  output register holds a word.
REQ-012 out_ready  input  1  downstream accepts when out_valid && out_ready.

Function
REQ-013 Transfer on channel i SHALL occur when in_valid[i] && in_ready[i] at a clock edge; output transfer when out_valid && out_ready.
REQ-014 load_en SHALL be (!out_valid || out_ready), combinational.
REQ-015 Grant SHALL be the first index g with in_valid[g]=1, searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_INPUTS.
REQ-016 in_ready SHALL be one-hot at bit g when load_en and any in_valid set; all zero otherwise.
REQ-017 in_ready SHALL depend only on in_valid, rr_ptr, out_valid, out_ready; never on in_data.
REQ-018 On transfer from g: out_data <= channel g data, out_sel <= g, out_valid <= 1, rr_ptr <= (g+1) mod NUM_INPUTS, next edge.
REQ-019 load_en with no in_valid set: out_valid <= 0; out_data, out_sel, rr_ptr hold.
REQ-020 !load_en (out_valid && !out_ready): out_data, out_sel, out_valid, rr_ptr SHALL hold; in_ready all zero.
REQ-021 Latency SHALL be 1 cycle from input transfer to out_valid; sustained throughput 1 word/cycle when out_ready held 1.
REQ-022 Simultaneous output drain and new load in one cycle SHALL be supported with no bubble.
REQ-023 rr_ptr wrap: grant of NUM_INPUTS-1 SHALL set rr_ptr to 0.
REQ-024 Fairness: with all channels continuously valid and out_ready=1, each channel SHALL be granted exactly once per NUM_INPUTS consecutive transfers.
REQ-025 Non-power-of-two NUM_INPUTS: indices >= NUM_INPUTS SHALL never be granted or appear on out_sel.
REQ-026 Data SHALL pass unmodified; no width conversion.

Reset
REQ-027 While rst_n=0 at a clock edge: out_valid <= 0, out_data <= 0, out_sel <= 0, rr_ptr <= 0.
REQ-028 in_ready SHALL be all zero in any cycle where rst_n=0, regardless of load_en.
REQ-029 Reset asserted mid-stream SHALL discard the held word; no transfer counted on that edge.
REQ-030 First grant after reset release SHALL search from channel 0.

Verification
REQ-031 Reset: rst_n=0 two cycles, in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0 after edge.
REQ-032 Single channel: in_valid=4'b0100, ch2=0xDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0xDEADBEEF, out_sel=2, out_valid=1.
REQ-033 Round-robin: in_valid=4'b1111 held, out_ready=1, 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3; one transfer per cycle.
REQ-034 Backpressure: out_valid=1 holding 0x11 from ch1, out_ready=0 for 3 cycles with in_valid=4'b1111 -> in_ready=0, out_data stays 0x11; out_ready=1 -> ch2 granted same cycle, out_sel=2 next cycle.
REQ-035 Skip and wrap: rr_ptr=3, in_valid=4'b0010 -> grant ch1, rr_ptr becomes 2; then in_valid=4'b1000 -> grant ch3, rr_ptr becomes 0.
REQ-036 Mid-stream reset: streaming all channels, rst_n=0 one cycle -> out_valid=0 next cycle; after release first out_sel=0.

Source files
------------

// File: rtl/para_rr_mux.sv
// Round-robin N:1 multiplexer with a single registered output stage.
// The search starts at the channel after the last one granted, so every requester is served in turn.
module para_rr_mux #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_INPUTS = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_INPUTS-1:0]            in_valid,
   output logic [NUM_INPUTS-1:0]            in_ready,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [((NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1)-1:0] out_sel,
   output logic                             out_valid,
   input  logic                             out_ready
);

   localparam int SEL_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   logic [SEL_WIDTH-1:0] rr_ptr;
   logic [SEL_WIDTH-1:0] grant;
   logic [SEL_WIDTH-1:0] next_ptr;
   logic                 any_valid;
   logic                 load_en;
   int                   idx;

   assign load_en = !out_valid || out_ready;

   // Walk offsets from farthest to nearest so the channel closest to rr_ptr wins.
   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      idx       = 0;
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
         if (in_valid[idx]) begin
            grant     = SEL_WIDTH'(idx);
            any_valid = 1'b1;
         end
      end
   end

   assign next_ptr = (grant == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;
   assign in_ready = (rst_n && load_en && any_valid) ? (NUM_INPUTS'(1) << grant) : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         rr_ptr    <= '0;
      end else if (load_en) begin
         if (any_valid) begin
            out_data  <= in_data[grant*DATA_WIDTH +: DATA_WIDTH];
            out_sel   <= grant;
            out_valid <= 1'b1;
            rr_ptr    <= next_ptr;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
